// File: rtl/keypad_scan.sv
// keypad_scan: scans a 4x4 active-low key matrix one column at a time, debounces over whole scans
// and emits a hex key code with a one-cycle strobe. Define KEYPAD_REPEAT_EN for held-key auto-repeat.
module keypad_scan #(
  parameter int SCAN_DIV       = 4096,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             scan_end;
  logic [1:0]       col_idx;
  logic [3:0]       col_oh;
  logic [3:0]       row_p0;
  logic [3:0]       row_p1;
  logic [15:0]      hit;
  logic [15:0]      hit_next;
  logic [4:0]       hit_cnt;
  logic [3:0]       hit_code;
  logic             single;
  logic             match;
  logic             do_accept;
  logic             rep_fire;
  logic [3:0]       cand;
  logic [3:0]       press_cnt;
  logic [3:0]       rel_cnt;

  assign tick     = (div_cnt == DIV_LAST);
  assign scan_end = tick && (col_idx == 2'd3);
  assign col_oh   = 4'b0001 << col_idx;
  assign col      = ~col_oh;

  // Stage p0/p1: row synchroniser, prescaler and column stepping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_p0  <= 4'b1111;
      row_p1  <= 4'b1111;
      div_cnt <= '0;
      col_idx <= 2'd0;
      hit     <= '0;
    end else begin
      row_p0 <= row;
      row_p1 <= row_p0;
      if (tick) begin
        div_cnt <= '0;
        col_idx <= col_idx + 2'd1;
        hit     <= hit_next;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Column 0 starts a fresh map; the current column's sample is merged so scan end sees the full scan.
  always_comb begin
    hit_next = (col_idx == 2'd0) ? 16'h0000 : hit;
    for (int r = 0; r < 4; r++)
      if (!row_p1[r]) hit_next[r*4 +: 4] = hit_next[r*4 +: 4] | col_oh;
  end

  always_comb begin
    hit_cnt  = '0;
    hit_code = '0;
    for (int i = 0; i < 16; i++)
      if (hit_next[i]) begin
        hit_cnt  = hit_cnt + 5'd1;
        hit_code = 4'(i);
      end
  end

  // Multiple simultaneous hits are ghost-prone and count as no key.
  assign single = (hit_cnt == 5'd1);
  assign match  = single && (hit_code == cand);

  always_comb begin
    do_accept = 1'b0;
    if (scan_end && single)
      case (state)
        IDLE:     do_accept = (DEBOUNCE_SCANS == 1);
        DEBOUNCE: do_accept = match && (press_cnt == DB_LAST);
        default:  do_accept = 1'b0;
      endcase
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS + 1) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
  logic [REP_W-1:0] rep_cnt;

  assign rep_fire = scan_end && (state == HELD) && match && (rep_cnt == REP_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rep_cnt <= '0;
    else if (do_accept)
      rep_cnt <= '0;
    else if (scan_end && state == HELD)
      rep_cnt <= (!match || rep_fire) ? '0 : rep_cnt + REP_W'(1);
  end
`else
  // REPEAT_SCANS is always positive, so this is a constant zero.
  assign rep_fire = (REPEAT_SCANS < 0);
`endif

  // Stage p2: debounce FSM and registered key outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cand      <= '0;
      press_cnt <= '0;
      rel_cnt   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= rep_fire;
      if (do_accept) begin
        state     <= HELD;
        cand      <= hit_code;
        key_code  <= hit_code;
        key_valid <= 1'b1;
        key_down  <= 1'b1;
        press_cnt <= '0;
        rel_cnt   <= '0;
      end else if (scan_end) begin
        case (state)
          IDLE: begin
            if (single) begin
              cand      <= hit_code;
              press_cnt <= 4'd1;
              state     <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (!single) begin
              press_cnt <= '0;
              state     <= IDLE;
            end else if (match) begin
              press_cnt <= press_cnt + 4'd1;
            end else begin
              cand      <= hit_code;
              press_cnt <= 4'd1;
            end
          end
          HELD: begin
            if (match) begin
              rel_cnt <= '0;
            end else if (rel_cnt == DB_LAST) begin
              rel_cnt  <= '0;
              key_down <= 1'b0;
              state    <= IDLE;
            end else begin
              rel_cnt <= rel_cnt + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
